button_press_conditioner: RTL and testbench

//  Per-button input conditioner feeding the game top level. It turns one raw
//  ui_in pin into clean single-cycle events: press, release, long-press and

---
 rtl/games_common_pkg.sv | 14 +
 rtl/sync_2ff.sv | 24 ++
 rtl/button_press_conditioner.sv | 133 +++++++++++++
 tb/tb_button_press_conditioner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/games_common_pkg.sv
// Shared timing defaults and hold-state encoding for the game input conditioners.
package games_common_pkg;

    localparam int DEBOUNCE_CYCLES_DEF   = 16;
    localparam int LONG_PRESS_CYCLES_DEF = 50000;
    localparam int REPEAT_CYCLES_DEF     = 10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_press_conditioner.sv
// Raw button pin -> synchronized, debounced level plus single-cycle press,
// release, long-press and auto-repeat events.
module button_press_conditioner
    import games_common_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter int REPEAT_CYCLES     = REPEAT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       repeat_en,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output btn_state_e fsm_state_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              btn_s;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [REP_W-1:0]  rep_cnt_q;
    btn_state_e        state_q;
    logic              press_q, release_q, long_q, repeat_q;
    logic              level_rise, level_fall;

    sync_2ff u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (btn),
        .q_o     (btn_s)
    );

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (btn_s != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Edges are taken from the next level so the pulses line up with the new level's first cycle.
    assign level_rise = level_d & ~level_q;
    assign level_fall = ~level_d & level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (level_rise) begin
                        press_q    <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (level_fall) begin
                        release_q  <= 1'b1;
                        hold_cnt_q <= '0;
                        rep_cnt_q  <= '0;
                        state_q    <= ST_IDLE;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        long_q    <= 1'b1;
                        rep_cnt_q <= '0;
                        state_q   <= ST_LONG;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_LONG: begin
                    // hold_cnt_q stays parked at HOLD_LAST for the rest of the press.
                    if (level_fall) begin
                        release_q  <= 1'b1;
                        hold_cnt_q <= '0;
                        rep_cnt_q  <= '0;
                        state_q    <= ST_IDLE;
                    end else if (rep_cnt_q == REP_LAST) begin
                        repeat_q  <= repeat_en;
                        rep_cnt_q <= '0;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + REP_W'(1);
                    end
                end
                default: begin
                    hold_cnt_q <= '0;
                    rep_cnt_q  <= '0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign fsm_state_o   = state_q;

endmodule

// File: tb/tb_button_press_conditioner.sv
// Directed bench for button_press_conditioner with short timing parameters.
module tb_button_press_conditioner;
  import games_common_pkg::*;

  localparam int DEB   = 4;
  localparam int LONGP = 20;
  localparam int REP   = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn;
  logic       repeat_en;
  logic       level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  btn_state_e fsm_state;

  // clock / reset
  always #5 clk = ~clk;

  button_press_conditioner #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONGP),
    .REPEAT_CYCLES     (REP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .repeat_en     (repeat_en),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .fsm_state_o   (fsm_state)
  );

  // expected output word: {level, press, release, long, repeat}
  typedef struct {
    logic       b;
    logic       ren;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // driver: inputs change on the falling edge, outputs are read 1 ns after the rising edge
  task automatic step(input logic b, input logic ren, input logic rst);
    @(negedge clk);
    btn       = b;
    repeat_en = ren;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic check_outs(input string name, input int idx);
    logic [4:0] got;
    logic [4:0] exp;
    got = {level, press_pulse, release_pulse, long_pulse, repeat_pulse};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: {lvl,prs,rel,lng,rep} got %b expected %b", name, idx, got, exp);
    end
  endtask

  task automatic check_state(input string name, input btn_state_e exp);
    n_checks++;
    if (fsm_state !== exp) begin
      n_fail++;
      $display("FAIL %s: state got %0d expected %0d", name, fsm_state, exp);
    end
  endtask

  task automatic add_vec(input logic b, input logic lvl, input logic prs, input logic rel);
    vecs.push_back('{b: b, ren: 1'b1, exp: {lvl, prs, rel, 2'b00}});
  endtask

  task automatic add_run(input logic b, input int n, input logic lvl);
    for (int k = 0; k < n; k++) add_vec(b, lvl, 1'b0, 1'b0);
  endtask

  // btn high for steps 1..n_high; every event step is a hand-derived constant (0 = none)
  task automatic run_hold(input string name, input int n_high, input int n_total, input logic ren,
                          input int press_at, input int long_at, input int rel_at,
                          input int rep_a, input int rep_b, input int rep_c);
    for (int i = 1; i <= n_total; i++) begin
      logic e_lvl;
      e_lvl = (i >= press_at) && (rel_at == 0 || i < rel_at);
      exp_q.push_back({e_lvl, i == press_at, i == rel_at, i == long_at,
                       (i == rep_a) || (i == rep_b) || (i == rep_c)});
      step(i <= n_high, ren, 1'b0);
      check_outs(name, i);
    end
  endtask

  initial begin
    btn       = 1'b0;
    repeat_en = 1'b1;
    reset     = 1'b1;

    // reset state
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(5'b0);
      step(1'b0, 1'b1, 1'b1);
      check_outs("reset", i);
    end
    check_state("reset_state", ST_IDLE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

    // clean press held 10 cycles, then clean release
    add_run(1'b1, 5, 1'b0);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0);
    add_run(1'b1, 4, 1'b1);
    add_run(1'b0, 5, 1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1);
    add_run(1'b0, 2, 1'b0);
    // 3-cycle glitch is rejected
    add_run(1'b1, 3, 1'b0);
    add_run(1'b0, 6, 1'b0);
    // bounce 1,0,1,1,... accepted 6 edges after the last rising sample
    add_vec(1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0);
    add_run(1'b1, 5, 1'b0);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0);
    // bounce 0,1,0,0,... on release
    add_vec(1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0);
    add_run(1'b0, 5, 1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1);
    add_run(1'b0, 2, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp);
      step(vecs[i].b, vecs[i].ren, 1'b0);
      check_outs("table", i);
    end

    // long press + repeat; the repeat due at 46 collides with the release
    run_hold("long_rep", 40, 50, 1'b1, 6, 26, 46, 31, 36, 41);
    check_state("after_long_rep", ST_IDLE);
    // same hold with auto-repeat disabled; long timing restarts from 0
    run_hold("long_norep", 40, 50, 1'b0, 6, 26, 46, 0, 0, 0);
    // level falls on the long_pulse cycle: only release fires
    run_hold("coincident_rel", 20, 30, 1'b1, 6, 0, 26, 0, 0, 0);

    // reset in LONG on the cycle a repeat was due, button still held
    run_hold("pre_reset", 30, 30, 1'b1, 6, 26, 0, 0, 0, 0);
    check_state("pre_reset_state", ST_LONG);
    exp_q.push_back(5'b0);
    step(1'b1, 1'b1, 1'b1);
    check_outs("in_reset", 0);
    check_state("in_reset_state", ST_IDLE);
    run_hold("post_reset", 10, 20, 1'b1, 6, 0, 16, 0, 0, 0);
    check_state("final_state", ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
